mm1_mem_req: RTL and testbench
==============================

// Module: mm1_mem_req
// PURPOSE
//  MM1 stage memory-request issuer. Consumes the EX->MM1 pipeline-register outputs.
//  Drives the SRAM-like data-memory request channel (req/addr_ok) and generates the
//  MM1 stall that gates the EX->MM1 register wen. Tracks outstanding/cancelled requests
//  so MM2 can match or discard each data_ok.
// PARAMETERS
//  MAX_OUTST  2  max accepted requests awaiting data_ok
//  CNT_W      2  width of the outstanding and cancel counters (must hold MAX_OUTST)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   asynchronous active-low reset
//  flush             in   1   kill instruction in MM1 (exception/ertn/branch)
//  mm1_valid         in   1   valid instruction held in MM1 register
//  mm1_mm_re         in   1   load
//  mm1_mm_we         in   1   store
//  mm1_mm_access_sz  in   2   00 byte, 01 half, 10 word
//  mm1_mm_addr       in   32  effective address
//  mm1_mm_wdata      in   32  store data, LSB-aligned
//  mm2_allowin       in   1   MM2 accepts an instruction this cycle
//  data_addr_ok      in   1   memory accepted request
//  data_data_ok      in   1   memory returned a response
//  data_req          out  1   request valid
//  data_wr           out  1   1=store
//  data_size         out  2   = mm1_mm_access_sz
//  data_addr         out  32  = mm1_mm_addr
//  data_wstrb        out  4   byte enables (0000 for loads)
//  data_wdata        out  32  lane-replicated store data
//  mm1_stall         out  1   mm1_valid & !ready_go; drives EX->MM1 wen low
//  mm1_to_mm2_valid  out  1   mm1_valid & ready_go & !flush
//  mm1_req_issued    out  1   instruction passed to MM2 owns an accepted request
//  mm1_ale           out  1   misaligned access detected
//  data_ok_discard   out  1   current data_data_ok belongs to a cancelled request
// BEHAVIOUR
//  - Reset: state=IDLE, outst_cnt=0, cancel_cnt=0; all outputs 0 (mm1_valid also 0).
//  - mem = mm1_valid & (mm1_mm_re|mm1_mm_we) & !ale. can_issue = outst_cnt<MAX_OUTST.
//  - FSM:
//    - IDLE: data_req=mem&can_issue&!flush.
//      - req&addr_ok: ->IDLE if mm2_allowin, else ->DONE.
//      - req&!addr_ok: ->REQ.
//    - REQ: data_req=1, held until addr_ok; request is never withdrawn.
//      - addr_ok&!cancel_pend&!flush: ->IDLE if mm2_allowin, else ->DONE.
//      - addr_ok&(cancel_pend|flush): cancel_cnt++, ->IDLE.
//      - flush&!addr_ok: set cancel_pend, stay REQ.
//    - DONE: ready_go=1; mm2_allowin ->IDLE; flush: cancel_cnt++, ->IDLE.
//  - ready_go = !mem | (req&addr_ok) | state==DONE; 1 for ale instructions.
//  - Latency: addr_ok in the same cycle as req gives zero stall cycles.
//  - outst_cnt: +1 on req&addr_ok, -1 on data_ok; simultaneous = no change.
//  - cancel_cnt: data_ok_discard = data_ok & (cancel_cnt!=0); that data_ok decrements it.
//    Simultaneous increment and decrement = no change.
//  - wstrb (stores only):
//    - byte: 1<<addr[1:0]
//    - half: addr[1] ? 1100 : 0011
//    - word: 1111
//  - wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
//  - outst_cnt==MAX_OUTST: IDLE withholds req, stall asserted until a data_ok.
//  - mm1_req_issued=1 when mm1_to_mm2_valid and the instruction's request was accepted.
//  - Reset mid-request: counters and FSM cleared asynchronously; memory side resets too.
// CONFIGURATION
//  MM1_ALE_CHECK_EN defined:
//    - mm1_ale = valid mem op & ((sz==01 & addr[0]) | (sz==10 & addr[1:0]!=0)).
//    - An ale instruction issues no request and passes to MM2 with mm1_ale=1.
//  Undefined: mm1_ale tied 0; misaligned requests are issued as given.
// STRUCTURE
//  - defs.v holds the shared constants:
//    - size codes SZ_BYTE/SZ_HALF/SZ_WORD
//    - FSM codes MM1_IDLE/MM1_REQ/MM1_DONE
//  - One combinational sub-module, mm1_store_align (size, addr[1:0], wdata -> wstrb, wdata).
//    The FSM and counters stay in mm1_mem_req.
// TESTING
//  1) Word store, addr=0x1000, wdata=0x11223344, addr_ok same cycle:
//     -> req=1, wstrb=1111, mm1_stall=0, outst_cnt=1.
//  2) Byte store, addr=0x1003, wdata=0xAB; addr_ok 3 cycles late:
//     -> wdata=0xABABABAB, wstrb=1000, stall 3 cycles, req held steady.
//  3) Flush in REQ, addr_ok 2 cycles later:
//     -> cancel_cnt=1, next data_ok has data_ok_discard=1, then cancel_cnt=0.
//  4) MAX_OUTST=2, two loads accepted with no data_ok:
//     -> third load gets req=0 and stall=1; one data_ok -> req issued.
//  5) With MM1_ALE_CHECK_EN, half load at addr=0x2001:
//     -> mm1_ale=1, req=0, mm1_to_mm2_valid=1.
//     Without the macro: req=1, ale=0.
//  6) addr_ok with mm2_allowin=0:
//     -> DONE, stall=0, to_mm2_valid=1 held; allowin=1 -> IDLE, req_issued=1.

Source files
------------

// File: rtl/mm1_mem_req_pkg.sv
// Shared constants for the MM1 memory-request issuer:
// access-size codes and FSM state codes.
package mm1_mem_req_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] MM1_IDLE = 2'd0;
  localparam logic [1:0] MM1_REQ  = 2'd1;
  localparam logic [1:0] MM1_DONE = 2'd2;

endpackage

// File: rtl/mm1_mem_req_store_align.sv
// Store lane steering: byte enables and replicated
// write data from access size and low address bits.
module mm1_store_align
  import mm1_mem_req_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  // Select lanes and replicate data across the bus
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: wstrb_o = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/mm1_mem_req.sv
// MM1 data-memory request issuer: request FSM, stall and
// outstanding/cancel tracking. Option: MM1_ALE_CHECK_EN.
module mm1_mem_req
  import mm1_mem_req_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        mm1_valid,
  input  logic        mm1_mm_re,
  input  logic        mm1_mm_we,
  input  logic [1:0]  mm1_mm_access_sz,
  input  logic [31:0] mm1_mm_addr,
  input  logic [31:0] mm1_mm_wdata,
  input  logic        mm2_allowin,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  output logic        mm1_stall,
  output logic        mm1_to_mm2_valid,
  output logic        mm1_req_issued,
  output logic        mm1_ale,
  output logic        data_ok_discard
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic             cpend_q, cpend_d;
  logic             cancel_inc;

  logic ale, mem, can_issue;
  logic in_idle, in_req, in_done;
  logic acc, cxl, acc_own, ready_go;
  logic [3:0] al_wstrb;

`ifdef MM1_ALE_CHECK_EN
  assign ale = mm1_valid & (mm1_mm_re | mm1_mm_we) &
    (((mm1_mm_access_sz == SZ_HALF) & mm1_mm_addr[0]) |
     ((mm1_mm_access_sz == SZ_WORD) &
      (mm1_mm_addr[1:0] != 2'b00)));
`else
  assign ale = 1'b0;
`endif

  assign mem       = mm1_valid & (mm1_mm_re | mm1_mm_we) & ~ale;
  assign can_issue = outst_q < MAX_C;
  assign in_idle   = state_q == MM1_IDLE;
  assign in_req    = state_q == MM1_REQ;
  assign in_done   = state_q == MM1_DONE;

  // An acceptance in REQ after a flush belongs to a killed
  // instruction and must not release the one now in MM1.
  assign data_req = in_req |
    (in_idle & mem & can_issue & ~flush);
  assign acc      = data_req & data_addr_ok;
  assign cxl      = acc & in_req & (cpend_q | flush);
  assign acc_own  = acc & ~cxl;
  assign ready_go = ~mem | acc_own | in_done;

  assign mm1_stall        = mm1_valid & ~ready_go;
  assign mm1_to_mm2_valid = mm1_valid & ready_go & ~flush;
  assign mm1_req_issued   = mm1_to_mm2_valid &
    (acc_own | in_done);
  assign mm1_ale          = ale;
  assign data_ok_discard  = data_data_ok & (cancel_q != '0);

  assign data_wr    = mm1_mm_we;
  assign data_size  = mm1_mm_access_sz;
  assign data_addr  = mm1_mm_addr;
  assign data_wstrb = mm1_mm_we ? al_wstrb : 4'b0000;

  mm1_store_align u_align (
    .size_i    (mm1_mm_access_sz),
    .addr_lo_i (mm1_mm_addr[1:0]),
    .wdata_i   (mm1_mm_wdata),
    .wstrb_o   (al_wstrb),
    .wdata_o   (data_wdata)
  );

  // Request FSM next state and cancel bookkeeping
  always_comb begin
    state_d    = state_q;
    cpend_d    = cpend_q;
    cancel_inc = 1'b0;
    unique case (state_q)
      MM1_IDLE: begin
        cpend_d = 1'b0;
        if (acc)
          state_d = mm2_allowin ? MM1_IDLE : MM1_DONE;
        else if (data_req)
          state_d = MM1_REQ;
      end
      MM1_REQ: begin
        if (acc) begin
          cpend_d = 1'b0;
          if (cxl) begin
            cancel_inc = 1'b1;
            state_d    = MM1_IDLE;
          end else begin
            state_d = mm2_allowin ? MM1_IDLE : MM1_DONE;
          end
        end else if (flush) begin
          cpend_d = 1'b1;
        end
      end
      MM1_DONE: begin
        cpend_d = 1'b0;
        if (flush) begin
          cancel_inc = 1'b1;
          state_d    = MM1_IDLE;
        end else if (mm2_allowin) begin
          state_d = MM1_IDLE;
        end
      end
      default: begin
        state_d = MM1_IDLE;
        cpend_d = 1'b0;
      end
    endcase
  end

  // Outstanding and cancelled request counters
  always_comb begin
    outst_d  = outst_q;
    cancel_d = cancel_q;
    case ({acc, data_data_ok})
      2'b10:   outst_d = outst_q + ONE_C;
      2'b01:   outst_d = outst_q - ONE_C;
      default: ;
    endcase
    case ({cancel_inc, data_ok_discard})
      2'b10:   cancel_d = cancel_q + ONE_C;
      2'b01:   cancel_d = cancel_q - ONE_C;
      default: ;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MM1_IDLE;
      cpend_q  <= 1'b0;
      outst_q  <= '0;
      cancel_q <= '0;
    end else begin
      state_q  <= state_d;
      cpend_q  <= cpend_d;
      outst_q  <= outst_d;
      cancel_q <= cancel_d;
    end
  end

endmodule

// File: tb/tb_mm1_mem_req.sv
// Bench for mm1_mem_req: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_mm1_mem_req;

`ifdef MM1_ALE_CHECK_EN
  localparam bit ALE_EN = 1'b1;
`else
  localparam bit ALE_EN = 1'b0;
`endif
  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mm1_valid = 1'b0;
  logic        mm1_mm_re = 1'b0;
  logic        mm1_mm_we = 1'b0;
  logic [1:0]  mm1_mm_access_sz = 2'b00;
  logic [31:0] mm1_mm_addr = '0;
  logic [31:0] mm1_mm_wdata = '0;
  logic        mm2_allowin = 1'b0;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        mm1_stall, mm1_to_mm2_valid;
  logic        mm1_req_issued, mm1_ale, data_ok_discard;

  mm1_mem_req #(.MAX_OUTST(2), .CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .mm1_valid        (mm1_valid),
    .mm1_mm_re        (mm1_mm_re),
    .mm1_mm_we        (mm1_mm_we),
    .mm1_mm_access_sz (mm1_mm_access_sz),
    .mm1_mm_addr      (mm1_mm_addr),
    .mm1_mm_wdata     (mm1_mm_wdata),
    .mm2_allowin      (mm2_allowin),
    .data_addr_ok     (data_addr_ok),
    .data_data_ok     (data_data_ok),
    .data_req         (data_req),
    .data_wr          (data_wr),
    .data_size        (data_size),
    .data_addr        (data_addr),
    .data_wstrb       (data_wstrb),
    .data_wdata       (data_wdata),
    .mm1_stall        (mm1_stall),
    .mm1_to_mm2_valid (mm1_to_mm2_valid),
    .mm1_req_issued   (mm1_req_issued),
    .mm1_ale          (mm1_ale),
    .data_ok_discard  (data_ok_discard)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: counts of requests in flight and of
  // those whose instruction was killed, plus ownership of
  // the request currently on the bus / already accepted.
  int m_outst = 0;
  int m_cancel = 0;
  bit m_pend = 0;
  bit m_stale = 0;
  bit m_own = 0;
  bit e_ready;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_outst = 0; m_cancel = 0;
    m_pend = 0; m_stale = 0; m_own = 0;
  endtask

  task automatic step(input bit v, input bit re,
                      input bit we, input logic [1:0] sz,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input bit fl, input bit al,
                      input bit aok, input bit dok);
    bit ale, mem, req, acc, cxl, own, tmv, disc;
    int nb, off;
    logic [3:0] ws;
    logic [31:0] wx;
    mm1_valid = v; mm1_mm_re = re; mm1_mm_we = we;
    mm1_mm_access_sz = sz; mm1_mm_addr = a;
    mm1_mm_wdata = wd; flush = fl; mm2_allowin = al;
    data_addr_ok = aok; data_data_ok = dok;
    #1;
    nb  = 1 << sz;
    ale = ALE_EN && v && (re || we) &&
          ((a % nb) != 0);
    mem = v && (re || we) && !ale;
    req = m_pend ||
          (!m_own && mem && m_outst < MAXO && !fl);
    acc = req && aok;
    cxl = acc && m_pend && (m_stale || fl);
    own = acc && !cxl;
    e_ready = !mem || own || m_own;
    tmv = v && e_ready && !fl;
    disc = dok && m_cancel > 0;
    off = int'(a[1:0]) & ~(nb - 1) & 3;
    ws = we ? 4'(((1 << nb) - 1) << off) : 4'b0000;
    if (sz == 2'd0)      wx = wd[7:0] * 32'h01010101;
    else if (sz == 2'd1) wx = wd[15:0] * 32'h00010001;
    else                 wx = wd;
    chk("req", data_req, req);
    chk("stall", mm1_stall, v && !e_ready);
    chk("to_mm2", mm1_to_mm2_valid, tmv);
    chk("issued", mm1_req_issued, tmv && (own || m_own));
    chk("ale", mm1_ale, ale);
    chk("discard", data_ok_discard, disc);
    if (req && !m_stale) begin
      chk("wr", data_wr, we);
      chk("size", data_size, sz);
      chk("addr", data_addr, a);
      chk("wstrb", data_wstrb, ws);
      chk("wdata", data_wdata, wx);
    end
    @(posedge clk);
    m_outst  = m_outst + int'(acc) - int'(dok);
    m_cancel = m_cancel + int'(cxl) +
               int'(m_own && fl) - int'(disc);
    m_stale = req && !aok && m_pend && (m_stale || fl);
    m_pend  = req && !aok;
    if (m_own) m_own = !(fl || al);
    else       m_own = own && !al;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && m_outst > 0; k++)
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
  endtask

  bit cv, cre, cwe, fl, al, aok, dok, adv;
  logic [1:0] csz;
  logic [31:0] ca, cwd;
  int kind;

  initial begin
    @(negedge clk);
    #1;
    chk("rst_req", data_req, 0);
    chk("rst_stall", mm1_stall, 0);
    chk("rst_to_mm2", mm1_to_mm2_valid, 0);
    chk("rst_wstrb", data_wstrb, 0);
    chk("rst_discard", data_ok_discard, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // word store accepted at once
    step(1, 0, 1, 2, 32'h1000, 32'h11223344, 0, 1, 1, 0);
    drain();
    // byte store, addr_ok three cycles late
    repeat (3)
      step(1, 0, 1, 0, 32'h1003, 32'hAB, 0, 1, 0, 0);
    step(1, 0, 1, 0, 32'h1003, 32'hAB, 0, 1, 1, 0);
    drain();
    // flush while waiting for addr_ok
    step(1, 1, 0, 2, 32'h3000, 0, 0, 1, 0, 0);
    step(1, 1, 0, 2, 32'h3000, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    chk("cancel_cnt", m_cancel, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // outstanding limit
    step(1, 1, 0, 2, 32'h10, 0, 0, 1, 1, 0);
    step(1, 1, 0, 2, 32'h20, 0, 0, 1, 1, 0);
    step(1, 1, 0, 2, 32'h30, 0, 0, 1, 1, 0);
    step(1, 1, 0, 2, 32'h30, 0, 0, 1, 1, 1);
    step(1, 1, 0, 2, 32'h30, 0, 0, 1, 1, 0);
    drain();
    // misaligned half load
    step(1, 1, 0, 1, 32'h2001, 0, 0, 1, 1, 0);
    drain();
    // accepted while MM2 is blocked
    step(1, 1, 0, 2, 32'h40, 0, 0, 0, 1, 0);
    step(1, 1, 0, 2, 32'h40, 0, 0, 0, 0, 0);
    step(1, 1, 0, 2, 32'h40, 0, 0, 1, 0, 0);
    drain();

    // random traffic
    adv = 1;
    for (int i = 0; i < 3000; i++) begin
      if (adv) begin
        cv   = $urandom_range(0, 9) < 8;
        kind = $urandom_range(0, 2);
        cre  = kind == 1;
        cwe  = kind == 2;
        csz  = 2'($urandom_range(0, 2));
        ca   = $urandom;
        cwd  = $urandom;
      end
      fl  = $urandom_range(0, 15) == 0;
      al  = $urandom_range(0, 3) != 0;
      aok = $urandom_range(0, 2) != 0;
      dok = m_outst > 0 && $urandom_range(0, 2) == 0;
      step(cv, cre, cwe, csz, ca, cwd, fl, al, aok, dok);
      adv = !cv || (e_ready && al) || fl;
    end

    // asynchronous reset while a request is pending
    drain();
    step(1, 1, 0, 2, 32'h50, 0, 0, 1, 0, 0);
    mm1_valid = 0; mm1_mm_re = 0; mm1_mm_we = 0;
    mm1_mm_access_sz = 0; mm1_mm_addr = 0;
    mm1_mm_wdata = 0; flush = 0; mm2_allowin = 0;
    data_addr_ok = 0; data_data_ok = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", data_req, 0);
    chk("arst_stall", mm1_stall, 0);
    chk("arst_discard", data_ok_discard, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 2, 32'h60, 0, 0, 1, 0, 0);
    step(1, 1, 0, 2, 32'h60, 0, 0, 1, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
